cm0ik_ahb_sram_bridge: RTL and testbench

AHB-Lite slave that acts as the initiator for the integration-kit synchronous SRAM model, converting Cortex-M0 bus transfers into SRAM `CS`/`WE`/`ADDRESS`/`WDATA` cycles and returning `RDATA` as `HRDATA`. It sustains zero-wait-state reads and writes through a single-entry write buffer with read forwarding. It sits between the system AHB interconnect and each SRAM instance (code and data memories).

---
 rtl/cm0ik_ahb_sram_bridge_pkg.sv | 39 +++
 rtl/cm0ik_ahb_sram_bridge_if.sv | 25 ++
 rtl/cm0ik_ahb_sram_bridge_wbuf.sv | 56 +++++
 rtl/cm0ik_ahb_sram_bridge.sv | 133 +++++++++++++
 tb/tb_cm0ik_ahb_sram_bridge.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cm0ik_ahb_sram_bridge_pkg.sv
// Shared encodings, response-state type and byte-lane helpers for the AHB-to-SRAM bridge.
package cm0ik_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        RESP_OKAY,
        RESP_ERR1,
        RESP_ERR2
    } resp_state_t;

    // Sizes above a word are treated as a full word.
    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] mask;
        case (size)
            3'd0:    mask = 4'b0001 << addr;
            3'd1:    mask = addr[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                               input logic [31:0] over,
                                               input logic [3:0]  mask);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = mask[i] ? over[i*8 +: 8] : base[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/cm0ik_ahb_sram_bridge_if.sv
// AHB-Lite slave-side signal bundle for the SRAM bridge.
interface cm0ik_ahb_sram_bridge_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/cm0ik_ahb_sram_bridge_wbuf.sv
// Single-entry write buffer holding a write whose data phase collided with a read,
// with byte-wise forwarding into read data.
module cm0ik_sram_wbuf
    import cm0ik_sram_pkg::*;
#(
    parameter int ADDRWIDTH = 18
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 load,
    input  logic [ADDRWIDTH-1:0] load_addr,
    input  logic [3:0]           load_mask,
    input  logic [31:0]          load_data,
    input  logic                 drain_ack,
    input  logic                 wr_pend,
    output logic                 drain_req,
    output logic [ADDRWIDTH-1:0] buf_addr,
    output logic [3:0]           buf_mask,
    output logic [31:0]          buf_data,
    input  logic [ADDRWIDTH-1:0] fwd_addr,
    input  logic [31:0]          fwd_rdata,
    output logic [31:0]          fwd_data
);

    logic buf_valid;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_mask  <= '0;
            buf_data  <= '0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_addr  <= load_addr;
            buf_mask  <= load_mask;
            buf_data  <= load_data;
        end else if (drain_ack) begin
            buf_valid <= 1'b0;
        end
    end

    assign drain_req = buf_valid;

    // The SRAM still holds the old bytes of a buffered write, so overlay them on read data.
    assign fwd_data = (buf_valid && (buf_addr == fwd_addr)) ?
                      byte_merge(fwd_rdata, buf_data, buf_mask) : fwd_rdata;

    // A write data phase can only follow a write address phase, which always drains the buffer.
    always @(posedge CLK) begin
        if (!RESET) begin
            assert (!(wr_pend && buf_valid));
        end
    end

endmodule

// File: rtl/cm0ik_ahb_sram_bridge.sv
// Zero-wait-state AHB-Lite to synchronous SRAM bridge with a one-entry write buffer.
// Optional address range check with ERROR response: CM0IK_SRAM_BRIDGE_RANGE_EN.
module cm0ik_ahb_sram_bridge
    import cm0ik_sram_pkg::*;
#(
    parameter int          ADDRWIDTH = 18,
    parameter logic [31:0] MEMBASE   = 32'h00000000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    cm0ik_ahb_sram_bridge_if.slave  ahb,
    output logic [ADDRWIDTH-1:0]    ADDRESS,
    output logic                    CS,
    output logic [3:0]              WE,
    output logic [31:0]             WDATA,
    input  logic [31:0]             RDATA
);

    logic                 accept, in_range, acc_ok, rd_now, wr_now;
    logic                 rd_phase, wr_pend;
    logic [ADDRWIDTH-1:0] haddr_word, rd_addr, wr_addr;
    logic [3:0]           wr_mask;
    logic                 drain_req, drain_ack, buf_load;
    logic [ADDRWIDTH-1:0] buf_addr;
    logic [3:0]           buf_mask;
    logic [31:0]          buf_data, fwd_data;
    logic                 unused_bits;

    assign haddr_word = ahb.HADDR[ADDRWIDTH+1:2];
    assign accept     = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;

`ifdef CM0IK_SRAM_BRIDGE_RANGE_EN
    logic [31:0] offset;
    resp_state_t resp_state, resp_next;

    assign offset   = ahb.HADDR - MEMBASE;
    assign in_range = ({1'b0, offset} < (33'd4 << ADDRWIDTH));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) resp_state <= RESP_OKAY;
        else       resp_state <= resp_next;
    end

    // Out-of-range transfers get the two-cycle ERROR response; ERR2 is ready, so it can accept.
    always_comb begin
        resp_next = resp_state;
        case (resp_state)
            RESP_OKAY, RESP_ERR2: resp_next = (accept && !in_range) ? RESP_ERR1 : RESP_OKAY;
            RESP_ERR1:            resp_next = RESP_ERR2;
            default:              resp_next = RESP_OKAY;
        endcase
    end

    assign ahb.HREADYOUT = (resp_state != RESP_ERR1);
    assign ahb.HRESP     = (resp_state == RESP_OKAY) ? HRESP_OKAY : HRESP_ERROR;
    assign unused_bits   = ahb.HTRANS[0];
`else
    assign in_range      = 1'b1;
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = HRESP_OKAY;
    assign unused_bits   = ^{ahb.HTRANS[0], ahb.HADDR[31:ADDRWIDTH+2], MEMBASE};
`endif

    assign acc_ok = accept & in_range;
    assign rd_now = acc_ok & ~ahb.HWRITE;
    assign wr_now = acc_ok &  ahb.HWRITE;

    // Data-phase bookkeeping advances only when the bus moves on.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_phase <= 1'b0;
            wr_pend  <= 1'b0;
            rd_addr  <= '0;
            wr_addr  <= '0;
            wr_mask  <= '0;
        end else if (ahb.HREADY) begin
            rd_phase <= rd_now;
            wr_pend  <= wr_now;
            if (rd_now) rd_addr <= haddr_word;
            if (wr_now) begin
                wr_addr <= haddr_word;
                wr_mask <= byte_mask(ahb.HSIZE, ahb.HADDR[1:0]);
            end
        end
    end

    // SRAM port arbitration: read address phase, then live write data, then buffer drain.
    always_comb begin
        CS        = 1'b0;
        WE        = 4'h0;
        ADDRESS   = '0;
        WDATA     = '0;
        drain_ack = 1'b0;
        if (rd_now) begin
            CS      = 1'b1;
            ADDRESS = haddr_word;
        end else if (wr_pend) begin
            CS      = 1'b1;
            WE      = wr_mask;
            ADDRESS = wr_addr;
            WDATA   = ahb.HWDATA;
        end else if (drain_req) begin
            CS        = 1'b1;
            WE        = buf_mask;
            ADDRESS   = buf_addr;
            WDATA     = buf_data;
            drain_ack = 1'b1;
        end
    end

    assign buf_load = wr_pend & rd_now;

    cm0ik_sram_wbuf #(.ADDRWIDTH(ADDRWIDTH)) u_wbuf (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (buf_load),
        .load_addr (wr_addr),
        .load_mask (wr_mask),
        .load_data (ahb.HWDATA),
        .drain_ack (drain_ack),
        .wr_pend   (wr_pend),
        .drain_req (drain_req),
        .buf_addr  (buf_addr),
        .buf_mask  (buf_mask),
        .buf_data  (buf_data),
        .fwd_addr  (rd_addr),
        .fwd_rdata (RDATA),
        .fwd_data  (fwd_data)
    );

    assign ahb.HRDATA = rd_phase ? fwd_data : 32'h0;

endmodule

// File: tb/tb_cm0ik_ahb_sram_bridge.sv
// Directed bench for cm0ik_ahb_sram_bridge with a behavioural synchronous SRAM.
// Define CM0IK_SRAM_BRIDGE_RANGE_EN to also exercise the ERROR response path.
module tb_cm0ik_ahb_sram_bridge;
    import cm0ik_sram_pkg::*;

    localparam int ADDRWIDTH = 18;

    logic                 CLK   = 1'b0;
    logic                 RESET = 1'b1;
    logic [ADDRWIDTH-1:0] ADDRESS;
    logic                 CS;
    logic [3:0]           WE;
    logic [31:0]          WDATA;
    logic [31:0]          RDATA = '0;
    logic [31:0]          mem [0:255];

    int checks = 0;
    int errors = 0;

    cm0ik_ahb_sram_bridge_if ahb ();
    assign ahb.HREADY = ahb.HREADYOUT;

    cm0ik_ahb_sram_bridge #(.ADDRWIDTH(ADDRWIDTH), .MEMBASE(32'h0)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ahb     (ahb),
        .ADDRESS (ADDRESS),
        .CS      (CS),
        .WE      (WE),
        .WDATA   (WDATA),
        .RDATA   (RDATA)
    );

    always #5 CLK = ~CLK;

    // Synchronous SRAM: registered read data, byte-enabled writes.
    always @(posedge CLK) begin
        if (CS) begin
            if (WE == 4'h0) RDATA <= mem[ADDRESS[7:0]];
            else begin
                for (int i = 0; i < 4; i++)
                    if (WE[i]) mem[ADDRESS[7:0]][i*8 +: 8] <= WDATA[i*8 +: 8];
            end
        end
    end

    task automatic apply_stimulus(input logic sel, input logic [1:0] trans, input logic write,
                                  input logic [2:0] size, input logic [31:0] addr,
                                  input logic [31:0] wdata);
        ahb.HSEL   = sel;
        ahb.HTRANS = trans;
        ahb.HWRITE = write;
        ahb.HSIZE  = size;
        ahb.HADDR  = addr;
        ahb.HWDATA = wdata;
    endtask

    task automatic idle(input logic [31:0] wdata);
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, 3'd2, 32'h0, wdata);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_hreadyout"}, 32'(ahb.HREADYOUT), 32'h1);
        check_output({tag, "_hresp"},     32'(ahb.HRESP),     32'h0);
        check_output({tag, "_hrdata"},    ahb.HRDATA,         32'h0);
        check_output({tag, "_cs"},        32'(CS),            32'h0);
        check_output({tag, "_we"},        32'(WE),            32'h0);
        check_output({tag, "_address"},   32'(ADDRESS),       32'h0);
        check_output({tag, "_wdata"},     WDATA,              32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8'h11] <= 32'h0BADCAFE;
        mem[8'h14] <= 32'hA5A5A5A5;
        idle(32'h0);

        @(negedge CLK);
        check_reset_values("reset");
        next_cycle();
        RESET = 1'b0;

        // Single word write then read back
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0);
        @(negedge CLK);
        check_output("t1_waddr_cs", 32'(CS), 32'h0);
        next_cycle();
        idle(32'hDEADBEEF);
        @(negedge CLK);
        check_output("t1_wdata_cs", 32'(CS), 32'h1);
        check_output("t1_wdata_we", 32'(WE), 32'hF);
        check_output("t1_wdata_addr", 32'(ADDRESS), 32'h4);
        check_output("t1_wdata_wdata", WDATA, 32'hDEADBEEF);
        next_cycle();
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
        @(negedge CLK);
        check_output("t1_raddr_cs", 32'(CS), 32'h1);
        check_output("t1_raddr_we", 32'(WE), 32'h0);
        next_cycle();
        idle(32'h0);
        @(negedge CLK);
        check_output("t1_rdata", ahb.HRDATA, 32'hDEADBEEF);
        next_cycle();

        // Write immediately followed by a read of the same word
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h20, 32'h0);
        @(negedge CLK);
        check_output("t2_idle_hrdata", ahb.HRDATA, 32'h0);
        next_cycle();
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h11223344);
        @(negedge CLK);
        check_output("t2_collide_we", 32'(WE), 32'h0);
        check_output("t2_collide_addr", 32'(ADDRESS), 32'h8);
        next_cycle();
        idle(32'h0);
        @(negedge CLK);
        check_output("t2_fwd_hrdata", ahb.HRDATA, 32'h11223344);
        check_output("t2_drain_we", 32'(WE), 32'hF);
        check_output("t2_drain_addr", 32'(ADDRESS), 32'h8);
        check_output("t2_drain_wdata", WDATA, 32'h11223344);
        next_cycle();
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
        next_cycle();
        idle(32'h0);
        @(negedge CLK);
        check_output("t2_sram_hrdata", ahb.HRDATA, 32'h11223344);
        check_output("t2_empty_cs", 32'(CS), 32'h0);
        next_cycle();

        // Byte write into lane 1
        apply_stimulus(1'b1, HTRANS_SEQ, 1'b1, 3'd0, 32'h31, 32'h0);
        next_cycle();
        idle(32'h5555AA55);
        @(negedge CLK);
        check_output("t3_byte_we", 32'(WE), 32'h2);
        check_output("t3_byte_addr", 32'(ADDRESS), 32'hC);
        next_cycle();
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h30, 32'h0);
        next_cycle();
        idle(32'h0);
        @(negedge CLK);
        check_output("t3_byte_hrdata", ahb.HRDATA, 32'h0000AA00);
        next_cycle();

        // Buffer held across a run of reads
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h40, 32'h0);
        next_cycle();
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h40, 32'hCAFEF00D);
        next_cycle();
        apply_stimulus(1'b1, HTRANS_SEQ, 1'b0, 3'd2, 32'h44, 32'h0);
        @(negedge CLK);
        check_output("t4_rd0_hrdata", ahb.HRDATA, 32'hCAFEF00D);
        check_output("t4_rd1_we", 32'(WE), 32'h0);
        check_output("t4_rd1_addr", 32'(ADDRESS), 32'h11);
        next_cycle();
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h40, 32'h0);
        @(negedge CLK);
        check_output("t4_rd1_hrdata", ahb.HRDATA, 32'h0BADCAFE);
        check_output("t4_rd2_we", 32'(WE), 32'h0);
        next_cycle();
        idle(32'h0);
        @(negedge CLK);
        check_output("t4_rd2_hrdata", ahb.HRDATA, 32'hCAFEF00D);
        check_output("t4_drain_we", 32'(WE), 32'hF);
        check_output("t4_drain_addr", 32'(ADDRESS), 32'h10);
        check_output("t4_drain_wdata", WDATA, 32'hCAFEF00D);
        next_cycle();

        // Partial forwarding of an upper halfword over stored data
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, 3'd1, 32'h42, 32'h0);
        @(negedge CLK);
        check_output("t4b_waddr_cs", 32'(CS), 32'h0);
        next_cycle();
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h40, 32'h1234BEEF);
        next_cycle();
        idle(32'h0);
        @(negedge CLK);
        check_output("t4b_fwd_hrdata", ahb.HRDATA, 32'h1234F00D);
        check_output("t4b_drain_we", 32'(WE), 32'hC);
        check_output("t4b_drain_wdata", WDATA, 32'h1234BEEF);
        next_cycle();

        // Reset while a write sits in the buffer
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h50, 32'h0);
        next_cycle();
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h60, 32'h77777777);
        next_cycle();
        idle(32'h0);
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_values("t5_reset");
        next_cycle();
        RESET = 1'b0;
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h50, 32'h0);
        next_cycle();
        idle(32'h0);
        @(negedge CLK);
        check_output("t5_old_hrdata", ahb.HRDATA, 32'hA5A5A5A5);
        next_cycle();

`ifdef CM0IK_SRAM_BRIDGE_RANGE_EN
        // Out-of-range access: two-cycle ERROR, no SRAM access
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h00100000, 32'h0);
        @(negedge CLK);
        check_output("t6_addr_cs", 32'(CS), 32'h0);
        next_cycle();
        idle(32'h0);
        @(negedge CLK);
        check_output("t6_err1_hreadyout", 32'(ahb.HREADYOUT), 32'h0);
        check_output("t6_err1_hresp", 32'(ahb.HRESP), 32'h1);
        check_output("t6_err1_cs", 32'(CS), 32'h0);
        next_cycle();
        @(negedge CLK);
        check_output("t6_err2_hreadyout", 32'(ahb.HREADYOUT), 32'h1);
        check_output("t6_err2_hresp", 32'(ahb.HRESP), 32'h1);
        check_output("t6_err2_cs", 32'(CS), 32'h0);
        next_cycle();
        @(negedge CLK);
        check_output("t6_okay_hresp", 32'(ahb.HRESP), 32'h0);
        next_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
